// File: rtl/freelist_if.sv
// Rename/retire side of the physical-register free list.
// The rename and retirement logic drive it as master; the free list is the slave.
interface freelist_if #(
    parameter int PRW = 5
);
    logic [1:0]           alloc_req;
    logic [1:0][PRW-1:0]  alloc_preg;
    logic                 alloc_stall;
    logic [1:0]           free_en;
    logic [1:0][PRW-1:0]  free_preg;
    logic [1:0]           retire_cnt;
    logic                 flush;
    logic [PRW-1:0]       free_count;
    logic                 err;

    modport master (
        output alloc_req, free_en, free_preg, retire_cnt, flush,
        input  alloc_preg, alloc_stall, free_count, err
    );

    modport slave (
        input  alloc_req, free_en, free_preg, retire_cnt, flush,
        output alloc_preg, alloc_stall, free_count, err
    );
endinterface

// File: rtl/freelist.sv
// Circular free list of physical registers with a committed head for one-cycle flush recovery.
// Two grants per cycle to rename, two returns per cycle from retirement.
module freelist #(
    parameter int PREGS = 32,
    parameter int AREGS = 16,
    parameter int PRW   = 5,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    freelist_if.slave  fl_bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    // First preg of the initially free range; the top DEPTH pregs if the parameters disagree.
    localparam int BASE = (AREGS + DEPTH == PREGS) ? AREGS : PREGS - DEPTH;

    logic [PRW-1:0] fl_mem [DEPTH];
    logic [PW-1:0]  head_reg, rhead_reg, tail_reg;
    logic [PW-1:0]  head_next, rhead_next, tail_next;
    logic           err_reg, err_next;

    logic [1:0]     alloc_n, push_n, rc;
    logic [PW-1:0]  free_cnt, spec_cnt, head_p1, tail_p1;
    logic [PW:0]    fill;
    logic           stall, overflow, rc_bad, retire_past;
    logic           wr0_en, wr1_en;
    logic [PRW-1:0] wr0_data, wr1_data;
    logic [DEPTH-1:0] we;
    logic [PRW-1:0] wd [DEPTH];

    assign alloc_n  = {1'b0, fl_bus.alloc_req[0]} + {1'b0, fl_bus.alloc_req[1]};
    assign push_n   = {1'b0, fl_bus.free_en[0]} + {1'b0, fl_bus.free_en[1]};
    assign free_cnt = tail_reg - head_reg;
    assign spec_cnt = head_reg - rhead_reg;
    assign head_p1  = head_reg + PW'(1);
    assign tail_p1  = tail_reg + PW'(1);

    // Stall compares against the pre-push count: a same-cycle free never feeds a same-cycle grant.
    assign stall    = PW'(alloc_n) > free_cnt;
    assign fill     = {1'b0, free_cnt} + (PW+1)'(push_n);
    assign overflow = fill > (PW+1)'(DEPTH);

    assign rc_bad      = (fl_bus.retire_cnt == 2'd3);
    assign rc          = rc_bad ? 2'd0 : fl_bus.retire_cnt;
    assign retire_past = PW'(rc) > spec_cnt;
    assign rhead_next  = retire_past ? head_reg : rhead_reg + PW'(rc);

    always_comb begin
        head_next = head_reg;
        if (fl_bus.flush) begin
            head_next = rhead_next;
        end else if (!stall) begin
            head_next = head_reg + PW'(alloc_n);
        end
    end

    assign tail_next = overflow ? tail_reg : tail_reg + PW'(push_n);
    assign err_next  = err_reg | overflow | retire_past | rc_bad;

    // Pushes are compacted: the first valid return lands at tail, the second at tail+1.
    assign wr0_en   = (push_n != 2'd0) && !overflow;
    assign wr1_en   = (push_n == 2'd2) && !overflow;
    assign wr0_data = fl_bus.free_en[0] ? fl_bus.free_preg[0] : fl_bus.free_preg[1];
    assign wr1_data = fl_bus.free_preg[1];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic hit0, hit1;
            assign hit0   = wr0_en && (tail_reg[IW-1:0] == IW'(gi));
            assign hit1   = wr1_en && (tail_p1[IW-1:0] == IW'(gi));
            assign we[gi] = hit0 | hit1;
            assign wd[gi] = hit1 ? wr1_data : wr0_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_mem[i] <= PRW'(BASE + i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we[i]) begin
                    fl_mem[i] <= wd[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            rhead_reg <= '0;
            tail_reg  <= PW'(DEPTH);
            err_reg   <= 1'b0;
        end else begin
            head_reg  <= head_next;
            rhead_reg <= rhead_next;
            tail_reg  <= tail_next;
            err_reg   <= err_next;
        end
    end

    // Slot 1 takes the entry after slot 0's only when slot 0 is also allocating.
    assign fl_bus.alloc_preg[0] = fl_mem[head_reg[IW-1:0]];
    assign fl_bus.alloc_preg[1] = fl_bus.alloc_req[0] ? fl_mem[head_p1[IW-1:0]]
                                                      : fl_mem[head_reg[IW-1:0]];
    assign fl_bus.alloc_stall   = stall;
    assign fl_bus.free_count    = PRW'(free_cnt);
    assign fl_bus.err           = err_reg;
endmodule

// File: tb/tb_freelist.sv
// Bench for freelist: queue-based reference model checked every cycle, directed scenarios with
// literal expectations, then a randomized register-recycling phase.
module tb_freelist;
    localparam int PRW   = 5;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    freelist_if #(.PRW(PRW)) bus ();

    freelist #(.PREGS(32), .AREGS(16), .PRW(PRW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fl_bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: free queue in grant order, in-flight (unretired) allocations, committed pregs.
    int freeq[$];
    int specq[$];
    int freeable[$];
    bit merr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        freeq.delete();
        specq.delete();
        freeable.delete();
        for (int i = 0; i < DEPTH; i++) begin
            freeq.push_back(16 + i);
            freeable.push_back(i);
        end
        merr = 1'b0;
    endtask

    always @(negedge clk) begin
        int n, k, rc;
        bit stall, ovf;
        if (!rst_n) begin
            model_reset();
        end else begin
            n = int'(bus.alloc_req[0]) + int'(bus.alloc_req[1]);
            k = int'(bus.free_en[0]) + int'(bus.free_en[1]);
            stall = (n > freeq.size());
            chk("stall", 32'(bus.alloc_stall), 32'(stall));
            chk("free_count", 32'(bus.free_count), freeq.size());
            chk("err", 32'(bus.err), 32'(merr));
            if (!stall && bus.alloc_req[0])
                chk("preg0", 32'(bus.alloc_preg[0]), freeq[0]);
            if (!stall && bus.alloc_req[1])
                chk("preg1", 32'(bus.alloc_preg[1]), bus.alloc_req[0] ? freeq[1] : freeq[0]);

            ovf = (freeq.size() + k > DEPTH);
            rc = int'(bus.retire_cnt);
            if (rc == 3) begin
                merr = 1'b1;
                rc = 0;
            end
            if (rc > specq.size()) begin
                merr = 1'b1;
                rc = specq.size();
            end
            repeat (rc) freeable.push_back(specq.pop_front());
            if (!stall && !bus.flush)
                repeat (n) specq.push_back(freeq.pop_front());
            if (bus.flush)
                while (specq.size() > 0) freeq.push_front(specq.pop_back());
            if (ovf) begin
                merr = 1'b1;
            end else begin
                if (bus.free_en[0]) freeq.push_back(int'(bus.free_preg[0]));
                if (bus.free_en[1]) freeq.push_back(int'(bus.free_preg[1]));
            end
        end
    end

    task automatic drive(logic [1:0] req, logic [1:0] fen, int p0, int p1,
                         logic [1:0] rc, logic fl);
        bus.alloc_req    = req;
        bus.free_en      = fen;
        bus.free_preg[0] = PRW'(p0);
        bus.free_preg[1] = PRW'(p1);
        bus.retire_cnt   = rc;
        bus.flush        = fl;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int k, idx, p[2];
        logic [1:0] req, fen, rc;
        logic fl;

        idle();
        do_reset();

        // Two grants straight out of reset.
        drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("rst_grant0", 32'(bus.alloc_preg[0]), 16);
        chk("rst_grant1", 32'(bus.alloc_preg[1]), 17);
        chk("rst_nostall", 32'(bus.alloc_stall), 0);
        tick();
        drive(2'b01, 2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("fc_after2", 32'(bus.free_count), 14);
        chk("grant_18", 32'(bus.alloc_preg[0]), 18);
        tick();
        idle();

        // Slot 1 alone takes the head entry.
        do_reset();
        drive(2'b10, 2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("slot1_only", 32'(bus.alloc_preg[1]), 16);
        tick();
        idle();
        #1;
        chk("fc_15", 32'(bus.free_count), 15);

        // Drain, stall, and a same-cycle free that cannot satisfy the stalled request.
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
        repeat (8) tick();
        drive(2'b01, 2'b01, 5, 0, 2'd0, 1'b0);
        #1;
        chk("drained", 32'(bus.free_count), 0);
        chk("empty_stall", 32'(bus.alloc_stall), 1);
        tick();
        drive(2'b01, 2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("fc_1", 32'(bus.free_count), 1);
        chk("grant_5", 32'(bus.alloc_preg[0]), 5);
        chk("no_stall_1", 32'(bus.alloc_stall), 0);
        tick();
        idle();
        #1;
        chk("fc_0", 32'(bus.free_count), 0);

        // Flush after retiring two of six allocations.
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
        repeat (3) tick();
        drive(2'b00, 2'b00, 0, 0, 2'd2, 1'b0);
        tick();
        drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b1);
        tick();
        drive(2'b01, 2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("flush_fc", 32'(bus.free_count), 14);
        chk("flush_head", 32'(bus.alloc_preg[0]), 18);
        idle();

        // Flush with a same-cycle retire.
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
        repeat (3) tick();
        drive(2'b00, 2'b00, 0, 0, 2'd2, 1'b0);
        tick();
        drive(2'b00, 2'b00, 0, 0, 2'd1, 1'b1);
        tick();
        drive(2'b01, 2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("flushrt_fc", 32'(bus.free_count), 13);
        chk("flushrt_head", 32'(bus.alloc_preg[0]), 19);
        chk("flushrt_err", 32'(bus.err), 0);
        idle();

        // Illegal retire counts.
        do_reset();
        drive(2'b00, 2'b00, 0, 0, 2'd3, 1'b0);
        tick();
        idle();
        #1;
        chk("rc3_err", 32'(bus.err), 1);
        do_reset();
        drive(2'b01, 2'b00, 0, 0, 2'd0, 1'b0);
        tick();
        drive(2'b00, 2'b00, 0, 0, 2'd2, 1'b0);
        tick();
        idle();
        #1;
        chk("past_err", 32'(bus.err), 1);
        chk("past_fc", 32'(bus.free_count), 15);

        // Overflowing push is dropped; err is sticky until an asynchronous reset.
        do_reset();
        drive(2'b00, 2'b01, 7, 0, 2'd0, 1'b0);
        tick();
        idle();
        #1;
        chk("ovf_err", 32'(bus.err), 1);
        chk("ovf_fc", 32'(bus.free_count), 16);
        drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
        #1;
        chk("ovf_keep0", 32'(bus.alloc_preg[0]), 16);
        chk("ovf_keep1", 32'(bus.alloc_preg[1]), 17);
        idle();
        tick();
        chk("err_sticky", 32'(bus.err), 1);
        rst_n = 1'b0;
        #1;
        chk("async_err", 32'(bus.err), 0);
        chk("async_fc", 32'(bus.free_count), 16);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random legal traffic recycling pregs; pointers wrap many times.
        for (int cyc = 0; cyc < 600; cyc++) begin
            req = 2'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 15) == 0);
            rc  = 2'($urandom_range(0, specq.size() < 2 ? specq.size() : 2));
            k   = $urandom_range(0, 2);
            while (k > 0 && (k > freeable.size() || freeq.size() + specq.size() + k > DEPTH))
                k--;
            p[0] = 0;
            p[1] = 0;
            for (int j = 0; j < k; j++) begin
                idx = $urandom_range(0, freeable.size() - 1);
                p[j] = freeable[idx];
                freeable.delete(idx);
            end
            if (k == 2) fen = 2'b11;
            else if (k == 1) fen = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            else fen = 2'b00;
            if (fen == 2'b10) drive(req, fen, 0, p[0], rc, fl);
            else drive(req, fen, p[0], p[1], rc, fl);
            tick();
        end
        idle();
        tick();
        chk("wrap_no_err", 32'(bus.err), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/freelist.md
Name: freelist

Overview:
- Physical-register free list feeding the rename map table.
- Supplies up to two unused physical register numbers per cycle to rename for destination writes.
- Accepts up to two freed physical registers per cycle from retirement (old mappings of retiring writers).
- Keeps a committed head pointer so a pipeline flush returns every speculatively allocated register in one cycle.

Parameters:
PREGS, 32, number of physical GPRs
AREGS, 16, number of architectural GPRs
PRW, 5, physical register index width (clog2 PREGS)
DEPTH, 16, queue depth = PREGS-AREGS (maximum free registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc_req  in  2  rename slot i requests a free preg
alloc_preg  out  2xPRW  granted preg per slot (combinational)
alloc_stall  out  1  requested count exceeds free count; no pop this cycle
free_en  in  2  retirement frees free_preg[i]
free_preg  in  2xPRW  preg being returned
retire_cnt  in  2  number of allocating instructions retiring this cycle (0..2)
flush  in  1  squash all speculative allocations
free_count  out  PRW  current speculative free entries (0..DEPTH)
err  out  1  sticky: overflow, retire past head, or retire_cnt=3

Behaviour:
- Storage: circular array fl[DEPTH] of PRW-bit entries.
- Pointers are clog2(DEPTH)+1 bits wide, with a wrap bit:
  - head: speculative allocation point
  - rhead: committed allocation point
  - tail: push point
- free_count = tail - head (modulo arithmetic on full pointer width).
- Reset (rst_n low, asynchronous): fl[i]=AREGS+i (16..31); head=rhead=0; tail=DEPTH with wrap bit set; free_count=16; err=0. alloc_preg then reads 16 and 17.
- Allocation is all-or-nothing:
  - n = popcount(alloc_req); alloc_stall = (n > free_count).
  - If not stalled and no flush, head += n at the clock edge.
  - When stalled, no pop occurs and rename must hold.
- Grant mapping (combinational, no latency; the value is consumed on the edge where the pop occurs):
  - alloc_preg[0] = fl[head].
  - alloc_preg[1] = alloc_req[0] ? fl[head+1] : fl[head].
  - alloc_preg is don't-care when the slot's req is 0 or alloc_stall is 1.
- Free pushes:
  - Compacted: the first set free_en goes to fl[tail], the second to fl[tail+1].
  - tail += popcount(free_en).
  - If free_count plus pushes would exceed DEPTH, the write is dropped and err is set.
- Retire: rhead += retire_cnt.
  - If this would pass head, set err and saturate rhead to head.
  - retire_cnt=3 sets err and is treated as 0.
- Flush: at the clock edge, head <= rhead_next (rhead after this cycle's retire_cnt is applied). alloc_req is ignored that cycle (no pop); alloc_stall still reflects the combinational compare.
- Simultaneous events in one cycle:
  - Free pushes and retire are always applied, including under flush.
  - Alloc and free together: alloc_stall uses the pre-push free_count, so a same-cycle free cannot satisfy a same-cycle allocation.
  - Alloc of 2 with free_count=2 is legal and gives free_count=0, plus any pushes.
- Wrap-around: pointer arithmetic wraps modulo 2*DEPTH; index = low bits.
- Reset mid-operation: all pointers return to reset values immediately; in-flight allocations are discarded.
- Map-table pairing: alloc_preg[0]/[1] drive map_wr_data[0]/[1]; alloc_req mirrors map_wr_en.

Test Plan:
- Reset, then alloc_req=11 for one cycle -> alloc_preg=16,17, no stall; next cycle free_count=14, alloc_preg[0]=18.
- alloc_req=10 only (slot 1) at reset -> alloc_preg[1]=16; free_count 16->15.
- Allocate 2/cycle for 8 cycles -> free_count=0; then alloc_req=01 -> alloc_stall=1, head unchanged; same cycle free_en=01, free_preg=5 -> next cycle free_count=1, alloc_req=01 grants preg 5.
- Allocate 6 (16..21), retire_cnt=2, then flush -> free_count=14 and alloc_preg[0]=18; flush with retire_cnt=1 in the same cycle -> alloc_preg[0]=19.
- Wrap test: run 40 alloc/free cycles recycling pregs -> free_count stays consistent and pointers wrap with no err.
- Push a free when free_count=16 -> err=1 (sticky), queue contents unchanged; assert rst_n low mid-test -> err=0 and free_count=16 with no clock edge required.
